// File: rtl/sprite_blitter.sv
// sprite_blitter: blits sprite ROM pixels or a fill colour into a 320x240 frame buffer
module sprite_blitter #(
  parameter int          FB_W       = 320,
  parameter int          FB_H       = 240,
  parameter int          SPR_W      = 41,
  parameter int          SPR_H      = 42,
  parameter int          SPR_FRAMES = 5,
  parameter logic [11:0] KEY_COLOR  = 12'h0f0,
  parameter int          ADDR_W     = 18
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_clear,
  input  logic [11:0]       cmd_x,
  input  logic [11:0]       cmd_y,
  input  logic [2:0]        cmd_frame,
  input  logic              cmd_mirror,
  input  logic [11:0]       clear_color,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [11:0]       fb_data,
  output logic              busy,
  output logic              done
);
  localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, DRAW = 3'd2, FLUSH = 3'd3, REJECT = 3'd4;
  localparam int CW = $clog2(SPR_W > SPR_H ? SPR_W : SPR_H) + 1;
  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_W * FB_H - 1);
  logic [2:0]        state_q;
  logic [ADDR_W-1:0] rom_addr_q, fb_addr_q, base_q;
  logic [11:0]       fb_data_q, x_q, y_q;
  logic [CW-1:0]     r_q, c_q;
  logic              mir_q, s2v_q;
  logic [12:0]       px_q, py_q;
  logic              last_c, draw_we;
  logic [CW-1:0]     nc, nr;
  logic [ADDR_W-1:0] rom_next, acc_base, fb_calc;
  assign last_c   = c_q == CW'(SPR_W - 1);
  assign nc       = last_c ? '0 : c_q + 1'b1;
  assign nr       = last_c ? r_q + 1'b1 : r_q;
  assign rom_next = base_q + ADDR_W'(nr) * ADDR_W'(SPR_W) + ADDR_W'(mir_q ? CW'(SPR_W - 1) - nc : nc);
  assign acc_base = ADDR_W'(cmd_frame) * ADDR_W'(SPR_W * SPR_H);
  // Stage 2 qualifies the pixel that arrives from the ROM this cycle
  assign draw_we  = s2v_q && rom_data != KEY_COLOR && px_q < 13'(FB_W) && py_q < 13'(FB_H);
  assign fb_calc  = ADDR_W'(py_q) * ADDR_W'(FB_W) + ADDR_W'(px_q);
  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign done      = (state_q == CLEAR && fb_addr_q == FB_LAST) || state_q == FLUSH || state_q == REJECT;
  assign rom_addr  = rom_addr_q;
  assign fb_we     = state_q == CLEAR || draw_we;
  assign fb_addr   = draw_we ? fb_calc : fb_addr_q;
  assign fb_data   = draw_we ? rom_data : fb_data_q;
  // Command FSM, address generation and the stage-2 coordinate pipeline
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      base_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      r_q        <= '0;
      c_q        <= '0;
      mir_q      <= 1'b0;
      s2v_q      <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
    end else begin
      s2v_q <= state_q == DRAW;
      px_q  <= 13'(x_q) + 13'(c_q);
      py_q  <= 13'(y_q) + 13'(r_q);
      if (draw_we) begin
        fb_addr_q <= fb_calc;
        fb_data_q <= rom_data;
      end
      case (state_q)
        IDLE: if (cmd_valid) begin
          x_q    <= cmd_x;
          y_q    <= cmd_y;
          mir_q  <= cmd_mirror;
          r_q    <= '0;
          c_q    <= '0;
          base_q <= acc_base;
          if (cmd_clear) begin
            state_q   <= CLEAR;
            fb_addr_q <= '0;
            fb_data_q <= clear_color;
          end else if (int'(cmd_frame) >= SPR_FRAMES) begin
            state_q <= REJECT;
          end else begin
            state_q    <= DRAW;
            rom_addr_q <= acc_base + (cmd_mirror ? ADDR_W'(SPR_W - 1) : '0);
          end
        end
        CLEAR: begin
          state_q   <= fb_addr_q == FB_LAST ? IDLE : CLEAR;
          fb_addr_q <= fb_addr_q == FB_LAST ? fb_addr_q : fb_addr_q + 1'b1;
        end
        DRAW: if (last_c && r_q == CW'(SPR_H - 1)) begin
          state_q <= FLUSH;
        end else begin
          c_q        <= nc;
          r_q        <= nr;
          rom_addr_q <= rom_next;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: directed scoreboard bench for sprite_blitter
module tb_sprite_blitter;
  logic        clk = 0, reset_n = 0;
  logic        cmd_valid = 0, cmd_ready, cmd_clear = 0, cmd_mirror = 0;
  logic [11:0] cmd_x = 0, cmd_y = 0, clear_color = 0, rom_data = 0, fb_data;
  logic [2:0]  cmd_frame = 0;
  logic [17:0] rom_addr, fb_addr;
  logic        fb_we, busy, done;
  logic [11:0] rom [0:8609];
  logic [29:0] q [$];
  int checks = 0, failures = 0;
  int nwr, maxa, done_cyc, done_addr, extra_done, ready_bad, rdy_after;
  logic [17:0] ra1, ra41, a2, a3;
  logic [11:0] d3;
  logic        we2, we3, ab_we, ab_rdy, ab_done;

  sprite_blitter dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_clear(cmd_clear), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_frame(cmd_frame),
    .cmd_mirror(cmd_mirror), .clear_color(clear_color), .rom_addr(rom_addr),
    .rom_data(rom_data), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_addr < 18'd8610 ? rom[rom_addr] : 12'h000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (fb_we === 1'b1) begin
    nwr++;
    if (int'(fb_addr) > maxa) maxa = int'(fb_addr);
    if (q.size() == 0) chk("unexpected_write", {14'd0, fb_addr}, 32'hffffffff);
    else chk("fb_write", {2'b0, fb_addr, fb_data}, {2'b0, q.pop_front()});
  end

  task automatic run(input logic clr, input logic [11:0] x, input logic [11:0] y, input logic [2:0] fr,
                     input logic m, input logic [11:0] col, input int abort_at);
    int n;
    if (clr) for (int a = 0; a < 76800; a++) q.push_back({18'(a), col});
    else if (fr < 3'd5)
      for (int r = 0; r < 42; r++)
        for (int c = 0; c < 41; c++) begin
          logic [11:0] p;
          int px, py;
          p = rom[int'(fr) * 1722 + r * 41 + (m ? 40 - c : c)];
          px = int'(x) + c;
          py = int'(y) + r;
          if (p != 12'h0f0 && px < 320 && py < 240) q.push_back({18'(py * 320 + px), p});
        end
    nwr = 0; maxa = 0; done_cyc = 0; done_addr = 0; extra_done = 0; ready_bad = 0; rdy_after = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_clear = clr; cmd_x = x; cmd_y = y; cmd_frame = fr; cmd_mirror = m; clear_color = col;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0; cmd_clear = ~clr; cmd_x = ~x; cmd_y = ~y; cmd_frame = ~fr; cmd_mirror = ~m; clear_color = ~col;
    n = 1;
    forever begin
      if (n == 1) ra1 = rom_addr;
      if (n == 41) ra41 = rom_addr;
      if (n == 2) begin we2 = fb_we; a2 = fb_addr; end
      if (n == 3) begin we3 = fb_we; a3 = fb_addr; d3 = fb_data; end
      if (done && done_cyc != 0) extra_done++;
      if (done && done_cyc == 0) begin done_cyc = n; done_addr = int'(fb_addr); end
      if (cmd_ready && done_cyc == 0) ready_bad++;
      if (n == abort_at) begin
        reset_n = 0;
        @(posedge clk);
        @(negedge clk);
        ab_we = fb_we; ab_rdy = cmd_ready; ab_done = done;
        reset_n = 1;
        q.delete();
        break;
      end
      if (done_cyc != 0 && n == done_cyc + 1) begin rdy_after = int'(cmd_ready); break; end
      if (n > 80000) begin chk("timeout", 32'(n), 32'd0); break; end
      @(negedge clk);
      n++;
    end
    #1;
  endtask

  initial begin
    logic [17:0] pre;
    for (int i = 0; i < 8610; i++) rom[i] = ($urandom_range(3) == 0) ? 12'h0f0 : 12'($urandom);
    rom[0] = 12'h0f0; rom[1] = 12'h123; rom[3484] = 12'h456;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    chk("rst_ready", cmd_ready, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_we", fb_we, 0); chk("rst_rom_addr", rom_addr, 0);
    chk("rst_fb_addr", fb_addr, 0); chk("rst_fb_data", fb_data, 0);

    run(1, 0, 0, 0, 0, 12'h00f, 0);
    chk("clr_writes", nwr, 76800); chk("clr_done_cyc", done_cyc, 76800);
    chk("clr_done_addr", done_addr, 76799); chk("clr_ready_low", ready_bad, 0);
    chk("clr_extra_done", extra_done, 0); chk("clr_ready_after", rdy_after, 1); chk("clr_queue", q.size(), 0);

    run(0, 0, 0, 0, 0, 0, 0);
    chk("d1_done_cyc", done_cyc, 1723); chk("d1_ready_after", rdy_after, 1); chk("d1_ready_low", ready_bad, 0);
    chk("d1_we2", we2, 0); chk("d1_we3", we3, 1); chk("d1_a3", a3, 1); chk("d1_d3", d3, 12'h123);
    chk("d1_max_le_13160", maxa <= 13160, 1); chk("d1_queue", q.size(), 0);

    run(0, 10, 5, 2, 1, 0, 0);
    chk("d2_ra1", ra1, 3484); chk("d2_ra41", ra41, 3444); chk("d2_we2", we2, 1);
    chk("d2_a2", a2, 1610); chk("d2_done_cyc", done_cyc, 1723); chk("d2_queue", q.size(), 0);

    for (int i = 0; i < 1722; i++) rom[i] = 12'hfff;
    run(0, 300, 230, 0, 0, 0, 0);
    chk("d3_writes", nwr, 200); chk("d3_max", maxa, 76799);
    chk("d3_done_cyc", done_cyc, 1723); chk("d3_queue", q.size(), 0);

    run(0, 400, 10, 1, 0, 0, 0);
    chk("off_writes", nwr, 0); chk("off_done_cyc", done_cyc, 1723);

    pre = rom_addr;
    run(0, 0, 0, 5, 0, 0, 0);
    chk("rej_done_cyc", done_cyc, 1); chk("rej_writes", nwr, 0);
    chk("rej_rom_addr", ra1, pre); chk("rej_ready_after", rdy_after, 1);

    run(0, 20, 20, 1, 0, 0, 100);
    chk("ab_we", ab_we, 0); chk("ab_ready", ab_rdy, 1); chk("ab_done_now", ab_done, 0);
    chk("ab_no_done", done_cyc, 0);

    run(0, 0, 0, 7, 1, 0, 0);
    chk("post_rst_done_cyc", done_cyc, 1); chk("post_rst_writes", nwr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Writer-side counterpart to the VGA display path.
- Accepts draw/clear commands over a valid/ready handshake.
- For draw: reads sprite pixels from a sprite ROM and writes non-transparent pixels into a 320x240 12-bit frame buffer, which the display block then scans out.
- For clear: fills the whole frame buffer with one colour.
- Sits between game logic (command source) and the frame-buffer SRAM write port.

Parameters:
- FB_W, 320, frame buffer width in pixels
- FB_H, 240, frame buffer height in pixels
- SPR_W, 41, sprite width
- SPR_H, 42, sprite height
- SPR_FRAMES, 5, animation frames stored back-to-back in the ROM
- KEY_COLOR, 12'h0f0, transparent colour (never written)
- ADDR_W, 18, ROM/frame-buffer address width

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset (synchronous, active-low)
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept command
- cmd_clear  in  1  1 = clear command, 0 = draw command
- cmd_x  in  12  sprite left column in frame-buffer pixels (unsigned)
- cmd_y  in  12  sprite top row (unsigned)
- cmd_frame  in  3  sprite frame index
- cmd_mirror  in  1  horizontal mirror
- clear_color  in  12  fill colour for clear
- rom_addr  out  ADDR_W  sprite ROM read address
- rom_data  in  12  ROM data, valid 1 cycle after rom_addr
- fb_we  out  1  frame-buffer write strobe
- fb_addr  out  ADDR_W  frame-buffer write address
- fb_data  out  12  frame-buffer write data
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset and handshake:
  - Reset is synchronous, active-low: reset_n, clk.
  - Reset values: state IDLE, rom_addr 0, fb_we 0, fb_addr 0, fb_data 0, busy 0, done 0.
  - cmd_ready = (state==IDLE), so it is 1 in the first cycle after reset.
  - A command is accepted on the edge where cmd_valid && cmd_ready; all cmd_* fields and clear_color are latched then. Later input changes are ignored.
  - busy = (state != IDLE).
- States: IDLE, CLEAR, DRAW, FLUSH, REJECT.
- Transitions from IDLE on acceptance:
  - cmd_clear=1 -> CLEAR
  - else cmd_frame >= SPR_FRAMES -> REJECT
  - else -> DRAW
- CLEAR:
  - Counter a = 0..FB_W*FB_H-1, one per cycle.
  - fb_we=1, fb_addr=a, fb_data=latched colour.
  - done=1 in the cycle of the write to a=76799, then IDLE.
  - Total: 76800 write cycles, cycles 1..76800 after acceptance.
- DRAW:
  - Row counter r (0..SPR_H-1) is outer; column counter c (0..SPR_W-1) is inner; one ROM address per cycle.
  - rom_addr = frame*SPR_W*SPR_H + r*SPR_W + (mirror ? SPR_W-1-c : c).
  - Stage 2 (next cycle): coordinates px=x+c, py=y+r are computed 13 bits wide with no wrap, and carried in a register alongside the address.
  - fb_we = (rom_data != KEY_COLOR) && px < FB_W && py < FB_H.
  - fb_addr = py*FB_W + px; fb_data = rom_data.
  - When fb_we=0, fb_addr/fb_data hold their previous values.
  - After the address for (SPR_H-1, SPR_W-1) is issued -> FLUSH.
- FLUSH:
  - One cycle; performs the final stage-2 write (subject to the same qualifiers).
  - done=1 in this cycle, then IDLE.
  - Draw timeline: addresses in cycles 1..1722 after acceptance; done in cycle 1723; cmd_ready=1 in cycle 1724.
- REJECT:
  - One cycle; no ROM access and no writes; done=1; then IDLE.
- Clipping:
  - Fully off-screen sprites (x >= FB_W or y >= FB_H) still take the full 1723 cycles, with zero writes.
  - No negative coordinates are supported.
- Back-to-back commands: cmd_valid held high is accepted in the first IDLE cycle after done. Commands are never accepted while busy.
- Reset mid-operation: state returns to IDLE at that edge and fb_we=0 from that edge on. Writes already performed are not undone. No done pulse is generated for the aborted command.
- Widths: the address product frame*1722 + r*41 + c is at most 8609, and py*320+px is at most 76799; both fit in ADDR_W.

Test Plan:
- Reset, then clear with clear_color=12'h00f -> exactly 76800 writes, fb_addr 0..76799 in order, data 12'h00f, done pulse coincident with addr 76799, cmd_ready=0 throughout.
- Draw frame 0 at (0,0), mirror 0, ROM[0]=12'h0f0, ROM[1]=12'h123 -> no write to fb_addr 0; fb_addr 1 gets 12'h123 in cycle 3; last possible write is fb_addr 41*320+40=13160; done in cycle 1723.
- Draw frame 2 at (10,5), mirror 1 -> first rom_addr=3484, and its data is written to fb_addr 1610; rom_addr in cycle 41 is 3444.
- Draw frame 0 at (300,230), ROM all 12'hfff -> exactly 20*10=200 writes, max fb_addr 76799, no address >= 76800.
- Draw with cmd_frame=5 -> done in cycle 1 after acceptance, zero fb_we, rom_addr unchanged, cmd_ready=1 in cycle 2.
- Reset asserted in cycle 100 of a draw -> fb_we=0 and cmd_ready=1 after that edge, no done pulse; next command is accepted immediately after reset release.
